// File: rtl/i2c_master_clkgen.sv
// i2c_master_clkgen: programmable quarter-phase SCL/SDA timing generator with clock-stretch detection
module i2c_master_clkgen #(
  parameter int IHZ         = 8000000,
  parameter int OHZ         = 400000,
  parameter int CNT_W       = 16,
  parameter int STRETCH_MAX = 65535
) (
  input  logic             sys_clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             div_ld,
  input  logic [CNT_W-1:0] div_val,
  input  logic             stretch_en,
  input  logic             scl_in,
  output logic             scl_clk,
  output logic             sda_clk,
  output logic [1:0]       phase_idx,
  output logic             phase_tick,
  output logic             busy,
  output logic             stretching,
  output logic             stretch_to
);
  localparam int Q_RAW = IHZ / (4 * OHZ);
  localparam logic [CNT_W-1:0] Q_DEF = CNT_W'(Q_RAW < 2 ? 2 : Q_RAW);
  logic [1:0]       phase;
  logic [CNT_W-1:0] cnt, q, pend_val, ld_val;
  logic             pend, s1, s2, st_done, hold, adv, wrap, timeout;
  logic [31:0]      st_cnt;
  assign ld_val     = (div_val < CNT_W'(2)) ? CNT_W'(2) : div_val;
  assign scl_clk    = phase[1];
  assign sda_clk    = phase[0];
  assign phase_idx  = {phase[1], phase[1] ^ phase[0]};
  assign hold       = busy && stretch_en && phase == 2'b11 && !s2 && !st_done;
  assign stretching = hold;
  assign adv        = busy && !hold && cnt == q - CNT_W'(1);
  assign wrap       = adv && phase == 2'b10;
  assign timeout    = hold && STRETCH_MAX != 0 && st_cnt == 32'(STRETCH_MAX - 1);
  // A stretch restarts the quarter, so a full Q always follows the release.
  always_ff @(posedge sys_clk or negedge reset_n)
    if (!reset_n) begin
      s1         <= 1'b1;
      s2         <= 1'b1;
      phase      <= '0;
      cnt        <= '0;
      q          <= Q_DEF;
      pend       <= 1'b0;
      pend_val   <= '0;
      busy       <= 1'b0;
      phase_tick <= 1'b0;
      stretch_to <= 1'b0;
      st_done    <= 1'b0;
      st_cnt     <= '0;
    end else begin
      s1         <= scl_in;
      s2         <= s1;
      phase_tick <= adv;
      stretch_to <= timeout;
      st_cnt     <= hold ? st_cnt + 32'd1 : '0;
      st_done    <= busy && phase == 2'b11 && !adv && (st_done || timeout);
      if (!busy) begin
        busy  <= en;
        cnt   <= '0;
        phase <= '0;
        q     <= div_ld ? ld_val : pend ? pend_val : q;
        pend  <= 1'b0;
      end else begin
        cnt  <= (hold || adv) ? '0 : cnt + CNT_W'(1);
        pend <= div_ld || (pend && !wrap);
        if (adv) phase <= {phase[0], ~phase[1]};
        if (wrap) begin
          busy <= en;
          q    <= pend ? pend_val : q;
        end
        if (div_ld) pend_val <= ld_val;
      end
    end
endmodule

// File: tb/tb_i2c_master_clkgen.sv
// tb_i2c_master_clkgen: randomized timing checks of i2c_master_clkgen against arithmetic expectations
module tb_i2c_master_clkgen;
  localparam int CW = 16;
  localparam int QD = 5;
  localparam int BOUND = 2000;
  logic sys_clk = 1'b0, reset_n = 1'b0, en = 1'b0, en2 = 1'b0, div_ld = 1'b0;
  logic stretch_en = 1'b0, scl_in = 1'b1;
  logic [CW-1:0] div_val = '0;
  logic scl_clk, sda_clk, phase_tick, busy, stretching, stretch_to;
  logic scl_clk2, sda_clk2, phase_tick2, busy2, stretching2, stretch_to2;
  logic [1:0] phase_idx, phase_idx2;
  int checks = 0, errors = 0;
  always #5 sys_clk = ~sys_clk;
  i2c_master_clkgen dut (
    .sys_clk(sys_clk), .reset_n(reset_n), .en(en), .div_ld(div_ld), .div_val(div_val),
    .stretch_en(stretch_en), .scl_in(scl_in), .scl_clk(scl_clk), .sda_clk(sda_clk),
    .phase_idx(phase_idx), .phase_tick(phase_tick), .busy(busy), .stretching(stretching),
    .stretch_to(stretch_to));
  i2c_master_clkgen #(.STRETCH_MAX(16)) dut2 (
    .sys_clk(sys_clk), .reset_n(reset_n), .en(en2), .div_ld(div_ld), .div_val(div_val),
    .stretch_en(stretch_en), .scl_in(scl_in), .scl_clk(scl_clk2), .sda_clk(sda_clk2),
    .phase_idx(phase_idx2), .phase_tick(phase_tick2), .busy(busy2), .stretching(stretching2),
    .stretch_to(stretch_to2));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(negedge sys_clk);
  endtask
  function automatic logic sig(input int w);
    case (w)
      0: return busy;
      1: return sda_clk;
      2: return scl_clk;
      3: return busy2;
      default: return phase_tick;
    endcase
  endfunction
  function automatic logic [7:0] outs();
    return {scl_clk, sda_clk, phase_idx, phase_tick, busy, stretching, stretch_to};
  endfunction
  task automatic wait_sig(input int w, input logic v, output int n);
    n = 0;
    do begin step(); n++; end while (sig(w) !== v && n < BOUND);
  endtask
  task automatic wait_idx(input bit d2, input logic [1:0] ix, output int n);
    n = 0;
    do begin step(); n++; end
    while (!(d2 ? (phase_tick2 && phase_idx2 == ix) : (phase_tick && phase_idx == ix)) && n < BOUND);
  endtask
  task automatic load(input int v);
    div_val = CW'(v);
    div_ld = 1'b1;
    step();
    div_ld = 1'b0;
  endtask
  initial begin
    int n, q, h, v, cnt_s, cnt_t, tpos;
    bit se, act;
    step();
    step();
    check("reset_outputs", outs(), 0);
    reset_n = 1'b1;
    en = 1'b1;
    wait_sig(0, 1'b1, n); check("start_busy", n, 1);
    wait_sig(1, 1'b1, n); check("first_sda", n, QD);
    wait_sig(2, 1'b1, n); check("first_scl", n, QD);
    wait_sig(2, 1'b0, n); check("scl_high", n, 2 * QD);
    wait_sig(2, 1'b1, n); check("scl_low", n, 2 * QD);
    for (int i = 0; i < 4; i++) begin
      wait_sig(4, 1'b1, n);
      check("tick_gap", n, QD);
      check("tick_idx", phase_idx, (3 + i) % 4);
    end
    wait_idx(0, 2'd1, n);
    load(8);
    wait_idx(0, 2'd0, n); check("cur_period", n + 1, 3 * QD);
    wait_sig(1, 1'b1, n); check("new_sda_lead", n, 8);
    wait_idx(0, 2'd0, n); check("new_period", n + 8, 32);
    wait_idx(0, 2'd2, n);
    en = 1'b0;
    wait_sig(0, 1'b0, n); check("stop_tail", n, 16);
    check("stop_lines", {scl_clk, sda_clk}, 0);
    repeat (5) step();
    check("idle_hold", outs(), 0);
    load(1);
    en = 1'b1;
    wait_sig(0, 1'b1, n); check("restart_busy", n, 1);
    wait_sig(1, 1'b1, n); check("restart_sda", n, 2);
    wait_idx(0, 2'd0, n); check("clamp_rest", n, 6);
    wait_idx(0, 2'd0, n); check("clamp_period", n, 8);
    wait_idx(0, 2'd2, n);
    en = 1'b0;
    step();
    en = 1'b1;
    wait_idx(0, 2'd0, n); check("regrab_tail", n + 1, 4);
    check("regrab_busy", busy, 1);
    wait_idx(0, 2'd0, n); check("regrab_period", n, 8);
    wait_idx(0, 2'd3, n);
    step();
    load(6);
    check("bnd_tick", {phase_tick, phase_idx}, 3'b100);
    wait_idx(0, 2'd0, n); check("bnd_old_period", n, 8);
    wait_idx(0, 2'd0, n); check("bnd_new_period", n, 24);
    for (int i = 0; i < 10; i++) begin
      en = 1'b0;
      wait_sig(0, 1'b0, n);
      v = (i == 0) ? 5 : int'($urandom_range(14, 0));
      q = (v < 2) ? 2 : v;
      se = (i == 0) ? 1'b1 : 1'($urandom_range(1, 0));
      h = (i == 0) ? 30 : int'($urandom_range(40, 1));
      act = se && q >= 3;
      load(v);
      en = 1'b1;
      wait_sig(0, 1'b1, n); check("r_busy", n, 1);
      wait_sig(1, 1'b1, n); check("r_sda", n, q);
      wait_idx(0, 2'd2, n); check("r_q1", n, q);
      stretch_en = se;
      scl_in = 1'b0;
      cnt_s = 0;
      cnt_t = 0;
      n = 0;
      do begin
        step();
        n++;
        if (n == h) scl_in = 1'b1;
        cnt_s += int'(stretching);
        cnt_t += int'(stretch_to);
      end while (!(phase_tick && phase_idx == 2'd3) && n < BOUND);
      scl_in = 1'b1;
      stretch_en = 1'b0;
      check("r_high11", n, act ? h + 2 + q : q);
      check("r_stretch_len", cnt_s, act ? h : 0);
      check("r_no_timeout", cnt_t, 0);
      wait_idx(0, 2'd0, n); check("r_tail", n, q);
    end
    reset_n = 1'b0;
    en = 1'b0;
    #1;
    check("rst2_outputs", outs(), 0);
    step();
    reset_n = 1'b1;
    en2 = 1'b1;
    stretch_en = 1'b1;
    scl_in = 1'b0;
    wait_idx(1, 2'd2, n); check("to_reach11", n, 2 * QD + 1);
    n = 0;
    cnt_t = 0;
    tpos = -1;
    do begin
      step();
      n++;
      if (stretch_to2) begin
        cnt_t++;
        tpos = n;
      end
    end while (!(phase_tick2 && phase_idx2 == 2'd3) && n < BOUND);
    check("to_pulses", cnt_t, 1);
    check("to_pos", tpos, 16);
    check("to_phase_len", n, 16 + QD);
    wait_idx(1, 2'd0, n); check("to_complete", n, QD);
    en2 = 1'b0;
    scl_in = 1'b1;
    stretch_en = 1'b0;
    wait_sig(3, 1'b0, n); check("to_stop", n, 4 * QD);
    en = 1'b1;
    wait_sig(0, 1'b1, n);
    wait_idx(0, 2'd2, n);
    load(9);
    step();
    reset_n = 1'b0;
    #1;
    check("rst_mid_outputs", outs(), 0);
    step();
    reset_n = 1'b1;
    wait_sig(0, 1'b1, n); check("post_rst_busy", n, 1);
    wait_sig(1, 1'b1, n); check("post_rst_sda", n, QD);
    wait_idx(0, 2'd0, n); check("post_rst_rest", n, 3 * QD);
    wait_idx(0, 2'd0, n); check("post_rst_period", n, 4 * QD);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/i2c_master_clkgen.md
Name: i2c_master_clkgen

Overview:
- Parametrised, runtime-programmable successor to the fixed I2C master prescaler.
- Divides sys_clk into four quarter-phases per SCL period and drives scl_clk, plus sda_clk leading it by one quarter.
- Adds enable/graceful stop, a divider reloaded on period boundaries, slave clock-stretching detection with timeout, and phase strobes for the I2C master FSM.

Parameters:
- IHZ, 8000000, sys_clk frequency in Hz.
- OHZ, 400000, default SCL frequency in Hz; reset divider Q_DEF = IHZ/(4*OHZ), which is 5 at the defaults.
- CNT_W, 16, width of the quarter-period counter and divider register.
- STRETCH_MAX, 65535, maximum stretch length in sys_clk cycles before timeout; 0 disables the timeout.

Ports:
- sys_clk  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- en  in  1  run request; level-sensitive.
- div_ld  in  1  one-cycle strobe that loads div_val.
- div_val  in  CNT_W  quarter-period length in sys_clk cycles.
- stretch_en  in  1  enables clock-stretch detection.
- scl_in  in  1  sensed SCL bus line; asynchronous to sys_clk.
- scl_clk  out  1  generated SCL timing clock.
- sda_clk  out  1  SDA timing clock; leads scl_clk by one quarter.
- phase_idx  out  2  current quarter index 0..3.
- phase_tick  out  1  one-cycle pulse on the cycle a phase advances.
- busy  out  1  generator running.
- stretching  out  1  SCL high phase is being held by a slave.
- stretch_to  out  1  one-cycle pulse on stretch timeout.

Behaviour:
- Reset (reset_n=0, async):
  - all outputs 0.
  - phase register = 00, cnt = 0.
  - divider register Q = Q_DEF; pending-load flag cleared.
  - scl_in synchroniser flops = 1.
- Divider values:
  - div_val < 2 is clamped to 2.
  - Q is the number of sys_clk cycles per quarter.
- Phase register is Gray-coded, sequence 00 -> 01 -> 11 -> 10 -> 00.
  - scl_clk = phase[1] and sda_clk = phase[0]; both are direct flop outputs, so they are glitch-free.
  - phase_idx is the binary index: 00=0, 01=1, 11=2, 10=3.
- Idle state (busy=0): cnt=0, phase=00, outputs low.
- Start:
  - en=1 sampled while idle -> busy=1 on the next edge; cnt counts from 0.
  - When cnt==Q-1: cnt<=0, phase advances, phase_tick=1 for exactly that following cycle (registered).
  - First sda_clk rise is Q cycles after busy rises; first scl_clk rise is 2Q cycles after. Period is 4Q.
- Stop:
  - en=0 while busy: the current period completes.
  - On the 10->00 transition, busy<=0 and the block holds idle.
  - en re-asserted before that boundary -> continuous running, no gap.
- Divider load:
  - div_ld while idle -> Q updates on the next edge.
  - div_ld while busy -> value is held pending and applied at the next 10->00 boundary.
  - A second div_ld before that boundary overwrites the pending value.
  - The period in progress is never altered.
- Clock stretch:
  - scl_in passes through a 2-flop synchroniser giving scl_s.
  - While stretch_en=1, phase=11 and scl_s=0: cnt holds and stretching=1. A cycle counter tracks the hold.
  - Counting resumes the cycle after scl_s=1.
  - Stretch time adds to the high phase; the high phase is always at least Q cycles after release.
  - If the hold reaches STRETCH_MAX cycles (STRETCH_MAX != 0): stretch_to pulses for 1 cycle, stretching drops, and counting resumes regardless of scl_s.
  - No new stretch is recognised until the next phase 11.
  - stretch_en=0: scl_in is ignored.
- Simultaneous events:
  - en=0 plus a stretch -> the stretch is honoured, then the period completes, then the block stops.
  - div_ld on the boundary cycle itself -> the new value is applied at the following boundary.
  - Reset mid-operation -> immediate return to the reset state; any pending load is lost.

Test Plan:
- Defaults (Q=5), en=1 held from idle -> sda_clk rises after 5 cycles and scl_clk after 10. Period 20, sda leading by 5, phase_tick every 5 cycles, phase_idx 0,1,2,3.
- Mid-run div_ld with div_val=8 during phase 1 -> current period stays 20 cycles; next period 32. div_val=1 loaded while idle -> period 8 (clamped to Q=2).
- en dropped during phase 2 -> outputs continue to the 10->00 boundary, then busy=0 with scl_clk=sda_clk=0. Re-assert -> restart with sda_clk rising after Q cycles.
- stretch_en=1, scl_in held low 30 cycles after phase 11 entry -> stretching high for the hold (plus 2-cycle sync latency); high phase = 30+2+5 cycles; no stretch_to.
- STRETCH_MAX=16, scl_in stuck low -> stretch_to pulses once after 16 held cycles; generator resumes and completes the period.
- reset_n pulsed low mid-phase 2 with a pending div_ld -> all outputs 0 immediately; Q returns to 5; pending value discarded.
